// File: rtl/pulse_meas_pkg.sv
// pulse_meas_pkg -- types shared by the pulse measurement block.
//   pm_state_t : measurement FSM states (IDLE waits for the first edge,
//                MEAS times complete phases).
//   pm_rec_t   : one measurement record {width, level, ovf}. The width field
//                is sized for the widest supported counter; users keep only
//                the low _CNT_WIDTH bits.
package pulse_meas_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } pm_state_t;

  localparam int PM_REC_MAX_W = 64;

  typedef struct packed {
    logic [PM_REC_MAX_W-1:0] width;
    logic                    level;
    logic                    ovf;
  } pm_rec_t;

endpackage

// File: rtl/pulse_meas_outreg.sv
// pulse_meas_outreg -- single-entry output holding register with
// valid/ready handshake and a sticky drop flag.
// Ports:
//   io_clk, io_rst_n      : clock, asynchronous active-low reset
//   io_ld                 : a new record is offered this cycle
//   io_ld_width/level/ovf : the offered record
//   io_ready              : consumer accepts the held record
//   io_clr                : synchronous clear of io_drop
//   io_valid              : a record is held
//   io_width/level/ovf    : the held record
//   io_drop               : sticky, set when an offered record was lost
//
// Handshake: a held record transfers on any cycle with io_valid=1 and
// io_ready=1. The record fields never change while io_valid=1 and
// io_ready=0. An offered record is loaded when the register is empty or is
// being emptied in the same cycle; otherwise it is discarded and io_drop
// is set (set beats io_clr).
module pulse_meas_outreg
  import pulse_meas_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         io_clk,
  input  logic         io_rst_n,
  input  logic         io_ld,
  input  logic [W-1:0] io_ld_width,
  input  logic         io_ld_level,
  input  logic         io_ld_ovf,
  input  logic         io_ready,
  input  logic         io_clr,
  output logic         io_valid,
  output logic [W-1:0] io_width,
  output logic         io_level,
  output logic         io_ovf,
  output logic         io_drop
);

  pm_rec_t rec_q;
  logic    valid_q;
  logic    drop_q;
  logic    accept;
  logic    lose;

  assign accept = io_ld && (!valid_q || io_ready);
  assign lose   = io_ld && valid_q && !io_ready;

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      rec_q   <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      if (accept) begin
        rec_q.width <= PM_REC_MAX_W'(io_ld_width);
        rec_q.level <= io_ld_level;
        rec_q.ovf   <= io_ld_ovf;
        valid_q     <= 1'b1;
      end else if (valid_q && io_ready) begin
        valid_q <= 1'b0;
      end

      if (lose) begin
        drop_q <= 1'b1;
      end else if (io_clr) begin
        drop_q <= 1'b0;
      end
    end
  end

  assign io_valid = valid_q;
  assign io_width = rec_q.width[W-1:0];
  assign io_level = rec_q.level;
  assign io_ovf   = rec_q.ovf;
  assign io_drop  = drop_q;

  // Upper width bits are always zero (loaded by zero extension).
  logic unused_width_hi;
  assign unused_width_hi = |(rec_q.width >> W);

endmodule

// File: rtl/pulse_meas.sv
// pulse_meas -- measures the length of each complete high/low phase of a
// clean, synchronous input level and hands the result out as a record.
// Ports:
//   io_clk, io_rst_n : clock, asynchronous active-low reset
//   io_in            : debounced input level (already synchronous)
//   io_en            : measurement enable
//   io_clr           : clear the sticky io_drop flag
//   io_rise/io_fall  : one-cycle pulse, the cycle after an edge
//   io_valid/io_ready: record handshake
//   io_width         : completed phase length in cycles (saturating)
//   io_level         : level of the completed phase (1 = high)
//   io_ovf           : phase length reached the counter maximum
//   io_drop          : sticky, a record was lost while the last was held
module pulse_meas
  import pulse_meas_pkg::*;
#(
  parameter int _CNT_WIDTH = 32
) (
  input  logic                  io_clk,
  input  logic                  io_rst_n,
  input  logic                  io_in,
  input  logic                  io_en,
  input  logic                  io_clr,
  output logic                  io_rise,
  output logic                  io_fall,
  output logic                  io_valid,
  input  logic                  io_ready,
  output logic [_CNT_WIDTH-1:0] io_width,
  output logic                  io_level,
  output logic                  io_ovf,
  output logic                  io_drop
);

  localparam logic [_CNT_WIDTH-1:0] CNT_ONE = _CNT_WIDTH'(1);
  localparam logic [_CNT_WIDTH-1:0] CNT_MAX = '1;

  pm_state_t             state_q, state_n;
  logic [_CNT_WIDTH-1:0] cnt_q, cnt_n;
  logic                  in_d;
  logic                  edge_c;
  logic                  rec_ld;

  assign edge_c = io_in ^ in_d;

  // Input history and edge pulses. in_d keeps tracking io_in while disabled
  // so that an edge is never invented on re-enable.
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      in_d    <= 1'b0;
      io_rise <= 1'b0;
      io_fall <= 1'b0;
    end else begin
      in_d    <= io_in;
      io_rise <= io_en && edge_c && io_in;
      io_fall <= io_en && edge_c && !io_in;
    end
  end

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // cnt counts the cycles since the last edge; the edge cycle itself loads 1
  // so that a phase of N cycles reads N at its closing edge.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    rec_ld  = 1'b0;
    if (!io_en) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // First edge only starts timing: the phase before it is partial.
          if (edge_c) begin
            state_n = ST_MEAS;
            cnt_n   = CNT_ONE;
          end
        end
        ST_MEAS: begin
          if (edge_c) begin
            rec_ld = 1'b1;
            cnt_n  = CNT_ONE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_n = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // The completed phase had the level held before the edge, i.e. in_d.
  pulse_meas_outreg #(
    .W(_CNT_WIDTH)
  ) u_outreg (
    .io_clk      (io_clk),
    .io_rst_n    (io_rst_n),
    .io_ld       (rec_ld),
    .io_ld_width (cnt_q),
    .io_ld_level (in_d),
    .io_ld_ovf   (cnt_q == CNT_MAX),
    .io_ready    (io_ready),
    .io_clr      (io_clr),
    .io_valid    (io_valid),
    .io_width    (io_width),
    .io_level    (io_level),
    .io_ovf      (io_ovf),
    .io_drop     (io_drop)
  );

endmodule

// File: tb/tb_pulse_meas.sv
// tb_pulse_meas -- self-checking bench for pulse_meas with an 8-bit counter.
// Inputs change on the falling clock edge, outputs are compared on the next
// falling edge against a timestamp-based reference model.
module tb_pulse_meas;

  localparam int W = 8;
  localparam int MAXV = 255;

  logic         io_clk = 1'b0;
  logic         io_rst_n = 1'b0;
  logic         io_in = 1'b0;
  logic         io_en = 1'b0;
  logic         io_clr = 1'b0;
  logic         io_ready = 1'b0;
  logic         io_rise, io_fall, io_valid, io_level, io_ovf, io_drop;
  logic [W-1:0] io_width;

  int checks = 0;
  int failures = 0;

  pulse_meas #(._CNT_WIDTH(W)) dut (
    .io_clk   (io_clk),
    .io_rst_n (io_rst_n),
    .io_in    (io_in),
    .io_en    (io_en),
    .io_clr   (io_clr),
    .io_rise  (io_rise),
    .io_fall  (io_fall),
    .io_valid (io_valid),
    .io_ready (io_ready),
    .io_width (io_width),
    .io_level (io_level),
    .io_ovf   (io_ovf),
    .io_drop  (io_drop)
  );

  // clock
  always #5 io_clk = ~io_clk;

  // ---------------- reference model ----------------
  // Records are computed from edge timestamps: a record is the distance
  // between two consecutive enabled edges, clipped to the counter maximum.
  logic [W+1:0] exp_q[$];   // {width, level, ovf}; at most one held
  logic         m_in_d;
  logic         m_armed;
  int unsigned  m_cyc;
  int unsigned  m_tlast;
  logic         m_rise, m_fall, m_drop;

  task automatic model_reset();
    exp_q.delete();
    m_in_d  = 1'b0;
    m_armed = 1'b0;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m_drop  = 1'b0;
    m_cyc   = 0;
    m_tlast = 0;
  endtask

  task automatic model_step();
    logic        edge_b;
    logic        new_rec;
    logic        drop_set;
    int unsigned len;
    logic [W+1:0] nr;
    edge_b   = io_in ^ m_in_d;
    new_rec  = 1'b0;
    drop_set = 1'b0;
    nr       = '0;
    m_rise   = io_en && edge_b && io_in;
    m_fall   = io_en && edge_b && !io_in;
    if (!io_en) begin
      m_armed = 1'b0;
    end else if (edge_b) begin
      if (m_armed) begin
        len = m_cyc - m_tlast;
        nr  = {(len > MAXV) ? W'(MAXV) : W'(len), m_in_d, (len >= MAXV)};
        new_rec = 1'b1;
      end
      m_armed = 1'b1;
      m_tlast = m_cyc;
    end
    if (exp_q.size() > 0 && io_ready) void'(exp_q.pop_front());
    if (new_rec) begin
      if (exp_q.size() == 0) exp_q.push_back(nr);
      else drop_set = 1'b1;
    end
    if (drop_set) m_drop = 1'b1;
    else if (io_clr) m_drop = 1'b0;
    m_in_d = io_in;
    m_cyc++;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [W+1:0] h;
    chk("rise", int'(io_rise), int'(m_rise));
    chk("fall", int'(io_fall), int'(m_fall));
    chk("valid", int'(io_valid), int'(exp_q.size() > 0));
    chk("drop", int'(io_drop), int'(m_drop));
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      chk("width", int'(io_width), int'(h[W+1:2]));
      chk("level", int'(io_level), int'(h[1]));
      chk("ovf", int'(io_ovf), int'(h[0]));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left on a falling edge.
  task automatic cycle(input logic t_in, input logic t_en, input logic t_clr,
                       input logic t_rdy);
    io_in    = t_in;
    io_en    = t_en;
    io_clr   = t_clr;
    io_ready = t_rdy;
    @(posedge io_clk);
    model_step();
    @(negedge io_clk);
    model_check();
  endtask

  task automatic repeat_cycle(input int n, input logic t_in, input logic t_en,
                              input logic t_rdy);
    for (int i = 0; i < n; i++) cycle(t_in, t_en, 1'b0, t_rdy);
  endtask

  task automatic do_reset();
    @(negedge io_clk);
    io_rst_n = 1'b0;
    io_in    = 1'b0;
    io_en    = 1'b0;
    io_clr   = 1'b0;
    io_ready = 1'b0;
    @(negedge io_clk);
    @(negedge io_clk);
    io_rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       in_v, en_v, clr_v, rdy_v;
    logic       e_rise, e_fall, e_valid;
    logic [7:0] e_width;
    logic       e_level;
  } vec_t;

  vec_t vecs[8];
  logic cur_in;
  int   tdiv;

  initial begin
    // reset state
    do_reset();
    chk("rst_rise", int'(io_rise), 0);
    chk("rst_fall", int'(io_fall), 0);
    chk("rst_valid", int'(io_valid), 0);
    chk("rst_width", int'(io_width), 0);
    chk("rst_level", int'(io_level), 0);
    chk("rst_ovf", int'(io_ovf), 0);
    chk("rst_drop", int'(io_drop), 0);

    // basic 5-cycle high pulse: first edge only arms, closing edge records
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd5, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].in_v, vecs[i].en_v, vecs[i].clr_v, vecs[i].rdy_v);
      chk($sformatf("vec%0d_rise", i), int'(io_rise), int'(vecs[i].e_rise));
      chk($sformatf("vec%0d_fall", i), int'(io_fall), int'(vecs[i].e_fall));
      chk($sformatf("vec%0d_valid", i), int'(io_valid), int'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_width", i), int'(io_width), int'(vecs[i].e_width));
        chk($sformatf("vec%0d_level", i), int'(io_level), int'(vecs[i].e_level));
      end
    end

    // saturation: 300-cycle high phase
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    repeat_cycle(300, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("sat_valid", int'(io_valid), 1);
    chk("sat_width", int'(io_width), 255);
    chk("sat_ovf", int'(io_ovf), 1);
    chk("sat_level", int'(io_level), 1);

    // drop: low 3 is held, high 4 is lost, clr clears the flag
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat_cycle(3, 1'b0, 1'b1, 1'b0);
    repeat_cycle(4, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("drop_valid", int'(io_valid), 1);
    chk("drop_width", int'(io_width), 3);
    chk("drop_level", int'(io_level), 0);
    chk("drop_set", int'(io_drop), 1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("drop_clr", int'(io_drop), 0);
    chk("drop_hold_width", int'(io_width), 3);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);

    // back-to-back: new record lands in the acceptance cycle
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat_cycle(2, 1'b0, 1'b1, 1'b0);
    repeat_cycle(3, 1'b1, 1'b1, 1'b0);
    chk("b2b_first_width", int'(io_width), 2);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("b2b_valid", int'(io_valid), 1);
    chk("b2b_width", int'(io_width), 3);
    chk("b2b_level", int'(io_level), 1);
    chk("b2b_drop", int'(io_drop), 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("b2b_drain", int'(io_valid), 0);

    // enable dropped mid-phase: partial phase discarded, re-arm needed
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    repeat_cycle(3, 1'b1, 1'b1, 1'b1);
    repeat_cycle(2, 1'b1, 1'b0, 1'b1);
    repeat_cycle(2, 1'b0, 1'b0, 1'b1);
    repeat_cycle(3, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk("en_rearm_novalid", int'(io_valid), 0);
    chk("en_rearm_rise", int'(io_rise), 1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("en_valid", int'(io_valid), 1);
    chk("en_width", int'(io_width), 2);

    // asynchronous reset with a pending record and drop set
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat_cycle(2, 1'b0, 1'b1, 1'b0);
    repeat_cycle(2, 1'b1, 1'b1, 1'b0);
    repeat_cycle(3, 1'b0, 1'b1, 1'b0);
    repeat_cycle(2, 1'b1, 1'b1, 1'b0);
    chk("arst_pre_valid", int'(io_valid), 1);
    chk("arst_pre_drop", int'(io_drop), 1);
    #2 io_rst_n = 1'b0;
    #1;
    chk("arst_rise", int'(io_rise), 0);
    chk("arst_fall", int'(io_fall), 0);
    chk("arst_valid", int'(io_valid), 0);
    chk("arst_width", int'(io_width), 0);
    chk("arst_level", int'(io_level), 0);
    chk("arst_ovf", int'(io_ovf), 0);
    chk("arst_drop", int'(io_drop), 0);
    @(negedge io_clk);
    io_rst_n = 1'b1;
    model_reset();

    // randomized traffic, blocks with different toggle rates
    cur_in = 1'b0;
    for (int b = 0; b < 4; b++) begin
      tdiv = (b == 0) ? 3 : (b == 1) ? 8 : (b == 2) ? 2 : 100;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, tdiv - 1) == 0) cur_in = ~cur_in;
        cycle(cur_in, ($urandom_range(0, 39) != 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 3) != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_meas.md
PULSE_MEAS -- requirements
Module: pulse_meas

Interface
REQ-001 SHALL have parameter _CNT_WIDTH, default 32, meaning the width of the phase-length counter and of io_width.
REQ-002 SHALL have port io_clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-003 SHALL have port io_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port io_in, input, 1 bit: debounced level from the upstream filter stage, already synchronous to io_clk.
REQ-005 SHALL have port io_en, input, 1 bit: measurement enable.
REQ-006 SHALL have port io_clr, input, 1 bit: synchronous clear of the io_drop flag.
REQ-007 SHALL have port io_rise, output, 1 bit: one-cycle rising-edge pulse.
REQ-008 SHALL have port io_fall, output, 1 bit: one-cycle falling-edge pulse.
REQ-009 SHALL have port io_valid, output, 1 bit: a measurement record is held.
REQ-010 SHALL have port io_ready, input, 1 bit: consumer accepts the record.
REQ-011 SHALL have port io_width, output, _CNT_WIDTH bits: length of the completed phase, in cycles.
REQ-012 SHALL have port io_level, output, 1 bit: level of the completed phase (1 = high).
REQ-013 SHALL have port io_ovf, output, 1 bit: phase length saturated.
REQ-014 SHALL have port io_drop, output, 1 bit: sticky flag, set when a record was lost.

Function
REQ-015 SHALL register io_in once into in_d; edge = io_in XOR in_d; rise = edge AND io_in; fall = edge AND NOT io_in.
REQ-016 SHALL, while io_en=1, drive io_rise/io_fall high for exactly the one cycle after the edge cycle, in every state.
REQ-017 SHALL implement FSM states IDLE and MEAS.
REQ-018 SHALL, when io_en=0, force the FSM to IDLE, hold cnt at 0, suppress edge pulses and record generation, and retain any pending output record.
REQ-019 SHALL, in IDLE with io_en=1, move to MEAS on an edge and load cnt=1 without emitting a record, so the partial first phase is discarded.
REQ-020 SHALL, in MEAS with no edge, increment cnt by 1 per cycle, saturating at 2^_CNT_WIDTH-1.
REQ-021 SHALL, in MEAS on an edge, generate the record {width=cnt, level=in_d, ovf=(cnt==all-ones)} and reload cnt=1.
REQ-022 SHALL give a phase of N cycles io_width=N, with io_valid rising one cycle after the closing edge cycle.
REQ-023 SHALL, when io_valid=1 and io_ready=1, consume the record; io_valid falls next cycle unless a new record loads the same cycle.
REQ-024 SHALL, for a new record arriving when io_valid=0, or when io_valid=1 and io_ready=1, load it and set or keep io_valid=1.
REQ-025 SHALL, for a new record arriving when io_valid=1 and io_ready=0, discard the new record, keep the held record stable, and set io_drop.
REQ-026 SHALL hold io_width, io_level and io_ovf constant while io_valid=1 and io_ready=0.
REQ-027 SHALL clear io_drop on io_clr=1; if io_clr and a drop event coincide, the set wins.
REQ-028 SHALL let io_en falling mid-phase abort the phase with no record; re-enable restarts at REQ-019.

Reset
REQ-029 SHALL, on io_rst_n=0, immediately set: FSM=IDLE, cnt=0, in_d=0, io_rise=io_fall=io_valid=io_drop=0, io_width=0, io_level=0, io_ovf=0.
REQ-030 SHALL release reset synchronously to io_clk externally; the block adds no reset synchronizer.
REQ-031 SHALL, when reset asserts mid-phase or with a pending record, lose both without flagging io_drop.

Structure
REQ-032 SHALL place the FSM state enum and the record type {width, level, ovf} in shared package pulse_meas_pkg.
REQ-033 SHALL isolate the output holding register and handshake in sub-module pulse_meas_outreg; the edge detection and counter stay in the top level.

Verification (_CNT_WIDTH=8)
REQ-034 SHALL cover: enable, io_in 0->1 held 5 cycles ->0, io_ready=1 -> no record for the first edge; one record width=5, level=1, io_rise then io_fall pulses.
REQ-035 SHALL cover: high phase of 300 cycles -> width=255, ovf=1.
REQ-036 SHALL cover: io_ready=0, phases of 3 (low) then 4 (high) -> held record width=3, level=0 unchanged; io_drop=1; io_clr -> io_drop=0.
REQ-037 SHALL cover: io_ready=1 with a new record in the acceptance cycle -> io_valid stays 1 and the second record follows without a gap.
REQ-038 SHALL cover: io_en dropped mid-phase, re-enabled -> no record until two further edges; the partial phase is discarded.
REQ-039 SHALL cover: io_rst_n pulsed low mid-phase with io_valid=1 -> all outputs 0 asynchronously; io_drop=0.
